// File: rtl/score_pkg.sv
// Shared types for the score table: controller state encoding and default request code.
package score_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_COMPARE,
    S_WRITE,
    S_GLOBAL,
    S_HOLD
  } state_t;

  localparam logic [3:0] DEFAULT_REQ_CODE = 4'd5;

endpackage

// File: rtl/score_ram.sv
// Single-port synchronous score RAM with a RD_LAT-deep read pipeline.
// Out-of-range addresses never write and always read back as zero.
module score_ram #(
  parameter int SCORE_W     = 14,
  parameter int ID_W        = 5,
  parameter int NUM_PLAYERS = 32,
  parameter int RD_LAT      = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ID_W-1:0]    addr,
  input  logic [SCORE_W-1:0] wdata,
  output logic [SCORE_W-1:0] rdata
);

  localparam int AW = $clog2(NUM_PLAYERS);

  logic [SCORE_W-1:0] mem  [NUM_PLAYERS];
  logic [SCORE_W-1:0] pipe [RD_LAT];
  logic [AW-1:0]      idx;
  logic               addr_ok;

  assign idx     = addr[AW-1:0];
  assign addr_ok = {1'b0, addr} < (ID_W+1)'(NUM_PLAYERS);

  always_ff @(posedge clk) begin
    if (we && addr_ok) mem[idx] <= wdata;
    pipe[0] <= addr_ok ? mem[idx] : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[RD_LAT-1];

endmodule

// File: rtl/score_table.sv
// Per-player high-score table with running global best and win flags.
// Optional query port enabled by defining SCORE_TABLE_QUERY_EN.
module score_table
  import score_pkg::*;
#(
  parameter int         SCORE_W     = 14,
  parameter int         ID_W        = 5,
  parameter int         NUM_PLAYERS = 32,
  parameter int         RD_LAT      = 2,
  parameter logic [3:0] REQ_CODE    = DEFAULT_REQ_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         score_req,
  input  logic [ID_W-1:0]    playerID,
  input  logic [SCORE_W-1:0] Score,
`ifdef SCORE_TABLE_QUERY_EN
  input  logic               query_req,
  input  logic [ID_W-1:0]    query_id,
  output logic               query_valid,
  output logic [SCORE_W-1:0] query_score,
`endif
  output logic               personal_winner,
  output logic               global_winner,
  output logic               done,
  output logic               id_err,
  output logic               busy,
  output logic [SCORE_W-1:0] best_score,
  output logic [ID_W-1:0]    best_id
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t             state, nxt;
  logic [ID_W-1:0]    clr_addr;
  logic [CNT_W-1:0]   wait_cnt;
  logic [ID_W-1:0]    lat_id;
  logic [SCORE_W-1:0] lat_score;
  logic [SCORE_W-1:0] stored;
  logic               ram_we;
  logic [ID_W-1:0]    ram_addr;
  logic [SCORE_W-1:0] ram_wdata;
  logic [SCORE_W-1:0] ram_rdata;
  logic               req_hit, id_ok, clr_last, wait_last;
  logic               q_start, is_query;
  logic [ID_W-1:0]    q_id;

  assign req_hit   = (score_req == REQ_CODE);
  assign id_ok     = {1'b0, playerID} < (ID_W+1)'(NUM_PLAYERS);
  assign clr_last  = (clr_addr == ID_W'(NUM_PLAYERS - 1));
  assign wait_last = (wait_cnt == CNT_W'(RD_LAT - 1));
  assign busy      = (state != S_IDLE);

`ifdef SCORE_TABLE_QUERY_EN
  // A score request in the same IDLE cycle always takes priority over a query.
  assign q_start = (state == S_IDLE) && !req_hit && query_req;
  assign q_id    = query_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_query    <= 1'b0;
      query_valid <= 1'b0;
      query_score <= '0;
    end else begin
      query_valid <= 1'b0;
      if (state == S_IDLE) is_query <= q_start;
      if (state == S_WAIT && wait_last && is_query) begin
        query_valid <= 1'b1;
        query_score <= ram_rdata;
      end
    end
  end
`else
  assign q_start  = 1'b0;
  assign q_id     = '0;
  assign is_query = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_CLEAR;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_CLEAR:   if (clr_last) nxt = S_IDLE;
      S_IDLE:    if (req_hit) nxt = id_ok ? S_FETCH : S_HOLD;
                 else if (q_start) nxt = S_FETCH;
      S_FETCH:   nxt = S_WAIT;
      S_WAIT:    if (wait_last) nxt = is_query ? S_IDLE : S_COMPARE;
      S_COMPARE: nxt = S_WRITE;
      S_WRITE:   nxt = S_GLOBAL;
      S_GLOBAL:  nxt = S_HOLD;
      S_HOLD:    if (!req_hit) nxt = S_IDLE;
      default:   nxt = S_CLEAR;
    endcase
  end

  // CLEAR owns the RAM port; otherwise it addresses the latched player.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = lat_id;
    ram_wdata = lat_score;
    if (state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = '0;
    end else if (state == S_WRITE) begin
      ram_we = personal_winner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_addr        <= '0;
      wait_cnt        <= '0;
      lat_id          <= '0;
      lat_score       <= '0;
      stored          <= '0;
      personal_winner <= 1'b0;
      global_winner   <= 1'b0;
      done            <= 1'b0;
      id_err          <= 1'b0;
      best_score      <= '0;
      best_id         <= '0;
    end else begin
      done   <= 1'b0;
      id_err <= 1'b0;
      case (state)
        S_CLEAR: clr_addr <= clr_addr + ID_W'(1);
        S_IDLE: begin
          wait_cnt <= '0;
          if (req_hit) begin
            lat_id          <= playerID;
            lat_score       <= Score;
            personal_winner <= 1'b0;
            global_winner   <= 1'b0;
            id_err          <= !id_ok;
          end else if (q_start) begin
            lat_id <= q_id;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (wait_last) stored <= ram_rdata;
        end
        S_COMPARE: personal_winner <= (lat_score > stored);
        // Ties keep the previous holder of the global best.
        S_GLOBAL: begin
          done <= 1'b1;
          if (lat_score > best_score) begin
            best_score    <= lat_score;
            best_id       <= lat_id;
            global_winner <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  score_ram #(
    .SCORE_W    (SCORE_W),
    .ID_W       (ID_W),
    .NUM_PLAYERS(NUM_PLAYERS),
    .RD_LAT     (RD_LAT)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/score_table.md
# score_table

Parametrised per-player high-score table with running global best, successor to the fixed 32-entry score tracker. It sits between the game controller and the display/win logic. On each end-of-game request it compares the submitted score against that player's stored best and the global best, updates both, and reports personal/global win flags. Unlike the previous generation, it provides:
- full-depth table clear
- configurable RAM read latency
- out-of-range ID rejection
- a fixed-latency done pulse
- an optional query port

## Interface
Parameters:
- SCORE_W, 14, score width in bits
- ID_W, 5, player ID width
- NUM_PLAYERS, 32, table depth; must be ≤ 2**ID_W and ≥ 2
- RD_LAT, 2, score_ram read latency in cycles (≥ 1)
- REQ_CODE, 4'd5, score_req value that requests a submission

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- score_req  in  4  request code from game controller
- playerID  in  ID_W  submitting player
- Score  in  SCORE_W  submitted score, unsigned
- personal_winner  out  1  new personal best
- global_winner  out  1  new global best
- done  out  1  one-cycle pulse: submission result valid
- id_err  out  1  one-cycle pulse: playerID ≥ NUM_PLAYERS
- busy  out  1  high in any state except IDLE
- best_score  out  SCORE_W  current global best
- best_id  out  ID_W  holder of global best
- (SCORE_TABLE_QUERY_EN only) query_req in 1, query_id in ID_W, query_valid out 1, query_score out SCORE_W

## Operation
State machine: CLEAR → IDLE → FETCH → WAIT → COMPARE → WRITE → GLOBAL → HOLD → IDLE.

- **CLEAR:** entered on reset.
  - Writes 0 to addresses 0..NUM_PLAYERS-1, one per cycle (NUM_PLAYERS cycles), then goes to IDLE.
  - Requests during CLEAR are ignored, not queued.
- **IDLE:** when score_req == REQ_CODE, latch playerID and Score, then:
  - If the ID is in range, clear personal_winner/global_winner and go to FETCH.
  - If playerID ≥ NUM_PLAYERS, pulse id_err, drive both flags 0, and go to HOLD. No table access, no done pulse.
- **FETCH:** drive the read address.
- **WAIT:** RD_LAT cycles, then capture the RAM data.
- **COMPARE:**
  - Set personal = (latched score > stored).
  - Strictly greater wins; a tie is not a win.
- **WRITE:** always traversed, so latency is constant. Write enable is asserted only if personal.
- **GLOBAL:**
  - If latched score > best_score, update best_score and best_id, and set global_winner.
  - On a tie, the previous holder is kept.
  - Pulse done.
- **HOLD:** wait for score_req != REQ_CODE, then go to IDLE. This gives one submission per request assertion.
- **Flags:** personal_winner and global_winner are held until the next accepted request.
- **Arithmetic:** all comparisons are unsigned at SCORE_W. There is no arithmetic on scores, so no overflow is possible.

## Timing
- Reset values: personal_winner 0, global_winner 0, done 0, id_err 0, busy 1, best_score 0, best_id 0, query_valid 0, query_score 0.
- The table is undefined until CLEAR completes; busy falls NUM_PLAYERS cycles after rst deassertion.
- Latency: a request sampled at edge T gives done, with the flags valid, at edge T+RD_LAT+5.
- id_err: pulses at edge T+1.
- Re-trigger: a score_req held at REQ_CODE across CLEAR→IDLE is accepted in the first IDLE cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously), any pending write is abandoned, and CLEAR restarts from address 0.

## Configuration
Macro: SCORE_TABLE_QUERY_EN.
- **Defined:** the query ports exist.
  - query_req is honoured only in IDLE with no score request the same cycle; a score request wins a simultaneous query.
  - A query uses the FETCH/WAIT path, returns query_score with a one-cycle query_valid at T+RD_LAT+2, then returns to IDLE.
  - A query with an out-of-range ID returns query_score 0 with query_valid.
  - A query_req outside IDLE is dropped.
- **Undefined:** the ports are absent, and the query path and its state are removed.

## Structure
- Package score_pkg: the state enum and the REQ_CODE default.
- Sub-module score_ram: single-port synchronous RAM with write enable, parameters SCORE_W / ID_W / NUM_PLAYERS / RD_LAT.

## Test plan
- **Reset clear:** deassert rst → busy high exactly 32 cycles. Then, with QUERY_EN, query ids 0..31 → all return 0.
- **Personal and global win:** player 3 submits 100 → done at T+7; personal 1, global 1; best_id 3, best_score 100.
- **Lower score:** player 3 then submits 50 → personal 0, global 0; the stored score stays 100.
- **Tie on global:** player 7 submits 100 → personal 1, global 0; best_id stays 3.
- **Out-of-range ID:** playerID 40 (NUM_PLAYERS 32) → id_err pulse at T+1, no done, table unchanged.
- **Held request and reset:**
  - score_req held at 5 for 20 cycles → exactly one done; drop and reassert → a second done.
  - rst asserted during WAIT → outputs at reset values immediately; after the clear, player 3 reads 0.
